// File: rtl/spi_tx_fifo.sv
// Byte FIFO from the CPU SPI register block to the serializer; show-ahead read, level/full/empty/sticky overflow status.
// Latency: byte pushed at edge N is visible on rd_data after N, poppable at N+1; wr_ready = !full, rd_valid = !empty.
// Optional SPI_TX_FIFO_WATERMARK_EN adds registered low_wm (level <= LOW_WM).
module spi_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LOW_WM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              flush,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              clr_overflow
`ifdef SPI_TX_FIFO_WATERMARK_EN
  ,
  output logic              low_wm
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              push;
  logic              pop;

  // Status is decoded from the registered level only, so it never glitches mid-cycle.
  assign empty    = (level == '0);
  assign full     = (level == DEPTH_L);
  assign rd_valid = !empty;
  assign wr_ready = !full;
  assign rd_data  = mem[rd_ptr];

  assign push = wr_valid && !full;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LVL_ONE;
        2'b01:   level_nxt = level - LVL_ONE;
        default: level_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level <= level_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A refused push sets the flag even on a flush edge; set beats clear.
      if (wr_valid && full)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  // Storage is not reset; contents behind rd_ptr are only visible once level says so.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wr_ptr] <= wr_data;
  end

`ifdef SPI_TX_FIFO_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (reset)
      low_wm <= 1'b1;
    else
      low_wm <= (level_nxt <= (ADDR_W+1)'(LOW_WM));
  end
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Scoreboard bench for spi_tx_fifo: pushed bytes queue up, pops compare against the queue head.
module tb_spi_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LOW_WM = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic              flush = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              clr_overflow = 1'b0;
  logic              low_wm;

  spi_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOW_WM(LOW_WM)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef SPI_TX_FIFO_WATERMARK_EN
    ,
    .low_wm       (low_wm)
`endif
  );

`ifndef SPI_TX_FIFO_WATERMARK_EN
  assign low_wm = 1'b0;
`endif

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;
  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already stable; predict the edge from the model, clock it, then compare state.
  task automatic tick();
    bit m_full;
    bit do_push;
    bit do_pop;
    m_full  = (sb.size() == DEPTH);
    do_pop  = (sb.size() > 0) && rd_ready && !reset && !flush;
    do_push = wr_valid && !m_full && !reset && !flush;
    if (do_pop) begin
      chk("pop_data", {24'h0, rd_data}, {24'h0, sb[0]});
      void'(sb.pop_front());
      n_pops++;
    end
    if (do_push) sb.push_back(wr_data);
    if (reset) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (flush) sb.delete();
      if (wr_valid && m_full) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("level",    32'(level),    32'(sb.size()));
    chk("empty",    32'(empty),    32'(sb.size() == 0));
    chk("full",     32'(full),     32'(sb.size() == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
    chk("wr_ready", 32'(wr_ready), 32'(sb.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (sb.size() > 0) chk("head", {24'h0, rd_data}, {24'h0, sb[0]});
`ifdef SPI_TX_FIFO_WATERMARK_EN
    chk("low_wm", 32'(low_wm), 32'(sb.size() <= LOW_WM));
`endif
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rd_ready = 1'b1;
    while (sb.size() > 0 && guard < 4 * DEPTH) begin
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d;
    // T1: reset state, single byte, hold, pop
    tick();
    tick();
    reset = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    push_n(1, 8'hA5);
    chk("t1_data", {24'h0, rd_data}, 32'hA5);
    for (int i = 0; i < 3; i++) tick();
    chk("t1_hold", {24'h0, rd_data}, 32'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t1_empty", 32'(rd_valid), 32'd0);

    // T2: fill, overflow attempt, clear
    push_n(DEPTH, 8'h00);
    chk("t2_full", 32'(full), 32'd1);
    push_n(1, 8'hFF);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t2_clr", 32'(overflow), 32'd0);

    // T3: push+pop while full, then push+pop at 15
    wr_valid = 1'b1;
    wr_data  = 8'h40;
    rd_ready = 1'b1;
    tick();
    chk("t3_level15", 32'(level), 32'd15);
    wr_data = 8'h41;
    tick();
    chk("t3_level_hold", 32'(level), 32'd15);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    drain();

    // T4: push 3 / pop 3 across pointer wrap
    n_pops = 0;
    d = 0;
    while (d < 40) begin
      wr_valid = 1'b1;
      for (int i = 0; i < 3 && d < 40; i++) begin
        wr_data = 8'(d);
        d++;
        tick();
      end
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      while (sb.size() > 0) tick();
      rd_ready = 1'b0;
    end
    chk("t4_pops", 32'(n_pops), 32'd40);

    // T5: flush beats push and pop; overflow (still set from T3) survives
    chk("t5_ovf_pre", 32'(overflow), 32'd1);
    push_n(5, 8'h80);
    flush    = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 8'h99;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd1);

    // T6: reset mid-transfer, then refill with watermark sweep
    push_n(7, 8'h10);
    reset    = 1'b1;
    rd_ready = 1'b1;
    tick();
    reset    = 1'b0;
    rd_ready = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    push_n(1, 8'h3C);
    chk("t6_data", {24'h0, rd_data}, 32'h3C);
    push_n(4, 8'h50);
    chk("t6_level5", 32'(level), 32'd5);
`ifdef SPI_TX_FIFO_WATERMARK_EN
    chk("t6_low_wm5", 32'(low_wm), 32'd0);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
